// File: rtl/rsa_host_if.sv
// Host-side bridge to the RSA core stream interface: a plaintext FIFO feeds the
// i_valid/ack handshake and a credit-protected result FIFO collects o_valid/Mo.
module rsa_host_if #(
  parameter  int TX_DEPTH        = 8,
  parameter  int RX_DEPTH        = 8,
  parameter  int MAX_OUTSTANDING = 4,
  localparam int OW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [15:0]   in_data,
  output logic          rsa_i_valid,
  input  logic          rsa_ack,
  output logic [15:0]   rsa_Mi,
  input  logic          rsa_o_valid,
  input  logic [15:0]   rsa_Mo,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [15:0]   out_data,
  output logic [OW-1:0] outstanding,
  output logic [15:0]   sent_cnt,
  output logic [15:0]   recv_cnt,
  output logic          err
);
  localparam int TPW = $clog2(TX_DEPTH);
  localparam int RPW = $clog2(RX_DEPTH);
  localparam int TCW = TPW + 1;
  localparam int RCW = RPW + 1;

  typedef enum logic [0:0] {IDLE = 1'b0, REQ = 1'b1} state_t;
  state_t state_r, state_next_s;

  logic [15:0]   tx_mem_r [TX_DEPTH];
  logic [15:0]   rx_mem_r [RX_DEPTH];
  logic [TPW:0]  tx_wr_r, tx_rd_r;
  logic [RPW:0]  rx_wr_r, rx_rd_r;
  logic [RPW:0]  rx_count_s, rx_count_next_s;
  logic [OW-1:0] outstanding_next_s;
  logic          tx_empty_s, tx_full_s, rx_empty_s, rx_full_s;
  logic          tx_push_s, out_pop_s, rx_push_s, transfer_s, out_dec_s;
  logic          load_s, credit_now_s, credit_next_s, err_event_s;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign tx_empty_s = (tx_wr_r == tx_rd_r);
  assign tx_full_s  = (tx_wr_r[TPW] != tx_rd_r[TPW]) && (tx_wr_r[TPW-1:0] == tx_rd_r[TPW-1:0]);
  assign rx_empty_s = (rx_wr_r == rx_rd_r);
  assign rx_full_s  = (rx_wr_r[RPW] != rx_rd_r[RPW]) && (rx_wr_r[RPW-1:0] == rx_rd_r[RPW-1:0]);

  assign in_ready   = !tx_full_s;
  assign tx_push_s  = in_valid && !tx_full_s;
  assign out_valid  = !rx_empty_s;
  assign out_data   = rx_mem_r[rx_rd_r[RPW-1:0]];
  assign out_pop_s  = !rx_empty_s && out_ready;
  assign transfer_s = rsa_i_valid && rsa_ack;

  // A full result FIFO still accepts a word when the sink frees a slot that cycle.
  assign rx_push_s   = rsa_o_valid && (!rx_full_s || out_pop_s);
  assign out_dec_s   = rsa_o_valid && (outstanding != '0);
  assign err_event_s = rsa_o_valid && ((outstanding == '0) || (rx_full_s && !out_pop_s));

  assign rx_count_s         = rx_wr_r - rx_rd_r;
  assign rx_count_next_s    = rx_count_s + RCW'(rx_push_s) - RCW'(out_pop_s);
  assign outstanding_next_s = outstanding + OW'(transfer_s) - OW'(out_dec_s);

  assign credit_now_s  = ((32'(rx_count_s) + 32'(outstanding)) < 32'(RX_DEPTH)) &&
                         (32'(outstanding) < 32'(MAX_OUTSTANDING));
  assign credit_next_s = ((32'(rx_count_next_s) + 32'(outstanding_next_s)) < 32'(RX_DEPTH)) &&
                         (32'(outstanding_next_s) < 32'(MAX_OUTSTANDING));

  // Next-state and TX-head load decision; chaining in REQ uses post-transfer counts.
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (!tx_empty_s && credit_now_s) begin
          state_next_s = REQ;
          load_s       = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      REQ: begin
        if (transfer_s) begin
          if (!tx_empty_s && credit_next_s) begin
            state_next_s = REQ;
            load_s       = 1'b1;
          end else begin
            state_next_s = IDLE;
          end
        end else begin
          state_next_s = REQ;
        end
      end
      default: begin
        state_next_s = IDLE;
        load_s       = 1'b0;
      end
    endcase
  end

  // FSM state and the registered request outputs to the core.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      rsa_i_valid <= 1'b0;
      rsa_Mi      <= 16'h0000;
    end else if (clr) begin
      state_r     <= IDLE;
      rsa_i_valid <= 1'b0;
      rsa_Mi      <= 16'h0000;
    end else begin
      state_r     <= state_next_s;
      rsa_i_valid <= (state_next_s == REQ);
      if (load_s) begin
        rsa_Mi <= tx_mem_r[tx_rd_r[TPW-1:0]];
      end
    end
  end

  // FIFO pointers, in-flight count, statistics and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wr_r     <= '0;
      tx_rd_r     <= '0;
      rx_wr_r     <= '0;
      rx_rd_r     <= '0;
      outstanding <= '0;
      sent_cnt    <= 16'h0000;
      recv_cnt    <= 16'h0000;
      err         <= 1'b0;
    end else if (clr) begin
      tx_wr_r     <= '0;
      tx_rd_r     <= '0;
      rx_wr_r     <= '0;
      rx_rd_r     <= '0;
      outstanding <= '0;
      sent_cnt    <= 16'h0000;
      recv_cnt    <= 16'h0000;
      err         <= 1'b0;
    end else begin
      tx_wr_r     <= tx_wr_r + TCW'(tx_push_s);
      tx_rd_r     <= tx_rd_r + TCW'(load_s);
      rx_wr_r     <= rx_wr_r + RCW'(rx_push_s);
      rx_rd_r     <= rx_rd_r + RCW'(out_pop_s);
      outstanding <= outstanding_next_s;
      sent_cnt    <= sent_cnt + 16'(transfer_s);
      recv_cnt    <= recv_cnt + 16'(rsa_o_valid);
      err         <= err | err_event_s;
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (tx_push_s) begin
      tx_mem_r[tx_wr_r[TPW-1:0]] <= in_data;
    end
    if (rx_push_s) begin
      rx_mem_r[rx_wr_r[RPW-1:0]] <= rsa_Mo;
    end
  end

endmodule

// File: tb/tb_rsa_host_if.sv
// Scoreboard bench for rsa_host_if: the bench plays upstream source, RSA core and sink,
// queueing expected Mi words and results as stimulus is driven.
module tb_rsa_host_if;
  localparam int TXD  = 8;
  localparam int RXD  = 8;
  localparam int MAXO = 4;
  localparam int OW   = $clog2(MAXO + 1);

  logic          clk;
  logic          rst_n;
  logic          clr;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_data;
  logic          rsa_i_valid;
  logic          rsa_ack;
  logic [15:0]   rsa_Mi;
  logic          rsa_o_valid;
  logic [15:0]   rsa_Mo;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_data;
  logic [OW-1:0] outstanding;
  logic [15:0]   sent_cnt;
  logic [15:0]   recv_cnt;
  logic          err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [15:0] src_q[$];
  logic [15:0] mi_q[$];
  logic [15:0] res_q[$];
  logic        pend;
  logic [15:0] pw;
  logic        ret_en;
  int          nx;

  rsa_host_if #(.TX_DEPTH(TXD), .RX_DEPTH(RXD), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .rsa_i_valid(rsa_i_valid), .rsa_ack(rsa_ack), .rsa_Mi(rsa_Mi),
    .rsa_o_valid(rsa_o_valid), .rsa_Mo(rsa_Mo),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .outstanding(outstanding), .sent_cnt(sent_cnt), .recv_cnt(recv_cnt), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model;
    src_q.delete();
    mi_q.delete();
    res_q.delete();
    pend = 1'b0;
    pw   = 16'h0000;
    nx   = 0;
  endtask

  // Bench-side source/core/sink for n cycles (plus one to deliver a pending result).
  task automatic run(input int n);
    int c;
    logic push_ok, xfer, pop_ok;
    logic [15:0] mi, od, exp_w;
    c = 0;
    while (c < n || pend) begin
      in_valid = (src_q.size() > 0);
      if (src_q.size() > 0) in_data = src_q[0];
      else in_data = 16'h0000;
      rsa_o_valid = pend;
      rsa_Mo = pend ? pw : 16'h0000;
      #1;
      push_ok = in_valid && in_ready;
      xfer    = rsa_i_valid && rsa_ack;
      mi      = rsa_Mi;
      pop_ok  = out_valid && out_ready;
      od      = out_data;
      if (xfer) begin
        total_cnt++;
        if (mi_q.size() == 0) $display("FAIL mi_order: transfer of %h with nothing expected", mi);
        else begin
          exp_w = mi_q.pop_front();
          if (mi !== exp_w) $display("FAIL mi_order: got %h expected %h", mi, exp_w);
          else pass_cnt++;
        end
      end
      if (pop_ok) begin
        total_cnt++;
        if (res_q.size() == 0) $display("FAIL out_order: pop of %h with nothing expected", od);
        else begin
          exp_w = res_q.pop_front();
          if (od !== exp_w) $display("FAIL out_order: got %h expected %h", od, exp_w);
          else pass_cnt++;
        end
      end
      tick();
      if (push_ok) mi_q.push_back(src_q.pop_front());
      pend = 1'b0;
      if (xfer) begin
        nx++;
        if (ret_en) begin
          pend = 1'b1;
          pw   = mi ^ 16'hFFFF;
          res_q.push_back(pw);
        end
      end
      c++;
    end
    in_valid    = 1'b0;
    rsa_o_valid = 1'b0;
    rsa_Mo      = 16'h0000;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = 16'h0000;
    rsa_ack = 1'b0; rsa_o_valid = 1'b0; rsa_Mo = 16'h0000; out_ready = 1'b0; ret_en = 1'b0;
    clear_model();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic do_clr;
    clr = 1'b1; rsa_ack = 1'b0; in_valid = 1'b0; rsa_o_valid = 1'b0; out_ready = 1'b0;
    tick();
    clr = 1'b0;
    clear_model();
  endtask

  task automatic test_reset;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b expected 1", in_ready); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", out_valid); else pass_cnt++;
    total_cnt++; if (rsa_i_valid !== 1'b0) $display("FAIL rst_i_valid: got %b expected 0", rsa_i_valid); else pass_cnt++;
    total_cnt++; if (outstanding !== 3'd0) $display("FAIL rst_outstanding: got %0d expected 0", outstanding); else pass_cnt++;
    total_cnt++; if (sent_cnt !== 16'd0) $display("FAIL rst_sent: got %0d expected 0", sent_cnt); else pass_cnt++;
    total_cnt++; if (recv_cnt !== 16'd0) $display("FAIL rst_recv: got %0d expected 0", recv_cnt); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("FAIL rst_err: got %b expected 0", err); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    rsa_ack = 1'b1; ret_en = 1'b0;
    src_q.push_back(16'h1234);
    src_q.push_back(16'hBEEF);
    run(3);
    total_cnt++; if (nx !== 1) $display("FAIL b2b_first: transfers %0d expected 1", nx); else pass_cnt++;
    total_cnt++; if (rsa_i_valid !== 1'b1 || rsa_Mi !== 16'hBEEF)
      $display("FAIL b2b_second: i_valid %b Mi %h expected 1 BEEF", rsa_i_valid, rsa_Mi); else pass_cnt++;
    run(1);
    total_cnt++; if (sent_cnt !== 16'd2) $display("FAIL b2b_sent: got %0d expected 2", sent_cnt); else pass_cnt++;
    total_cnt++; if (outstanding !== 3'd2) $display("FAIL b2b_outstanding: got %0d expected 2", outstanding); else pass_cnt++;
    total_cnt++; if (rsa_i_valid !== 1'b0) $display("FAIL b2b_idle: i_valid %b expected 0", rsa_i_valid); else pass_cnt++;
    do_clr();
  endtask

  task automatic test_ack_stall;
    rsa_ack = 1'b0; ret_en = 1'b0;
    src_q.push_back(16'h5A5A);
    run(3);
    for (int k = 0; k < 5; k++) begin
      total_cnt++; if (rsa_i_valid !== 1'b1 || rsa_Mi !== 16'h5A5A)
        $display("FAIL stall_hold: cycle %0d i_valid %b Mi %h expected 1 5A5A", k, rsa_i_valid, rsa_Mi); else pass_cnt++;
      run(1);
    end
    total_cnt++; if (sent_cnt !== 16'd0) $display("FAIL stall_sent: got %0d expected 0", sent_cnt); else pass_cnt++;
    rsa_ack = 1'b1;
    run(1);
    total_cnt++; if (sent_cnt !== 16'd1) $display("FAIL stall_ack_sent: got %0d expected 1", sent_cnt); else pass_cnt++;
    total_cnt++; if (outstanding !== 3'd1) $display("FAIL stall_outstanding: got %0d expected 1", outstanding); else pass_cnt++;
    total_cnt++; if (rsa_i_valid !== 1'b0) $display("FAIL stall_idle: i_valid %b expected 0", rsa_i_valid); else pass_cnt++;
    do_clr();
  endtask

  task automatic test_credit_stall;
    rsa_ack = 1'b1; ret_en = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 10; i++) src_q.push_back(16'h1000 + 16'(i));
    run(40);
    total_cnt++; if (nx !== 8) $display("FAIL credit_stop: transfers %0d expected 8", nx); else pass_cnt++;
    total_cnt++; if (sent_cnt !== 16'd8) $display("FAIL credit_sent: got %0d expected 8", sent_cnt); else pass_cnt++;
    total_cnt++; if (recv_cnt !== 16'd8) $display("FAIL credit_recv: got %0d expected 8", recv_cnt); else pass_cnt++;
    total_cnt++; if (outstanding !== 3'd0) $display("FAIL credit_outstanding: got %0d expected 0", outstanding); else pass_cnt++;
    total_cnt++; if (rsa_i_valid !== 1'b0) $display("FAIL credit_idle: i_valid %b expected 0", rsa_i_valid); else pass_cnt++;
    out_ready = 1'b1;
    run(1);
    out_ready = 1'b0;
    run(20);
    total_cnt++; if (nx !== 9) $display("FAIL credit_release: transfers %0d expected 9", nx); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("FAIL credit_err: got %b expected 0", err); else pass_cnt++;
    out_ready = 1'b1;
    run(30);
    total_cnt++; if (nx !== 10) $display("FAIL credit_all: transfers %0d expected 10", nx); else pass_cnt++;
    total_cnt++; if (res_q.size() !== 0) $display("FAIL credit_drain: %0d results never seen expected 0", res_q.size()); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL credit_empty: out_valid %b expected 0", out_valid); else pass_cnt++;
    total_cnt++; if (recv_cnt !== 16'd10) $display("FAIL credit_recv_all: got %0d expected 10", recv_cnt); else pass_cnt++;
    do_clr();
  endtask

  task automatic test_max_outstanding;
    rsa_ack = 1'b1; ret_en = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 6; i++) src_q.push_back(16'h2000 + 16'(i));
    run(20);
    total_cnt++; if (nx !== 4) $display("FAIL maxo_stop: transfers %0d expected 4", nx); else pass_cnt++;
    total_cnt++; if (outstanding !== 3'd4) $display("FAIL maxo_count: got %0d expected 4", outstanding); else pass_cnt++;
    total_cnt++; if (rsa_i_valid !== 1'b0) $display("FAIL maxo_idle: i_valid %b expected 0", rsa_i_valid); else pass_cnt++;
    pend = 1'b1; pw = 16'h0C0C; res_q.push_back(16'h0C0C);
    run(10);
    total_cnt++; if (nx !== 5) $display("FAIL maxo_release: transfers %0d expected 5", nx); else pass_cnt++;
    total_cnt++; if (outstanding !== 3'd4) $display("FAIL maxo_after: got %0d expected 4", outstanding); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("FAIL maxo_err: got %b expected 0", err); else pass_cnt++;
    do_clr();
  endtask

  task automatic test_err_clr;
    rsa_ack = 1'b0; ret_en = 1'b0; out_ready = 1'b0;
    pend = 1'b1; pw = 16'h00AA; res_q.push_back(16'h00AA);
    run(1);
    total_cnt++; if (err !== 1'b1) $display("FAIL err_set: got %b expected 1", err); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b1 || out_data !== 16'h00AA)
      $display("FAIL err_word: out_valid %b data %h expected 1 00AA", out_valid, out_data); else pass_cnt++;
    total_cnt++; if (outstanding !== 3'd0) $display("FAIL err_no_underflow: got %0d expected 0", outstanding); else pass_cnt++;
    total_cnt++; if (recv_cnt !== 16'd1) $display("FAIL err_recv: got %0d expected 1", recv_cnt); else pass_cnt++;
    do_clr();
    total_cnt++; if (err !== 1'b0) $display("FAIL clr_err: got %b expected 0", err); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL clr_out_valid: got %b expected 0", out_valid); else pass_cnt++;
    total_cnt++; if (recv_cnt !== 16'd0) $display("FAIL clr_recv: got %0d expected 0", recv_cnt); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    rsa_ack = 1'b0; ret_en = 1'b0;
    for (int i = 0; i < 4; i++) src_q.push_back(16'h3000 + 16'(i));
    run(4);
    total_cnt++; if (rsa_i_valid !== 1'b1) $display("FAIL mid_pre: i_valid %b expected 1", rsa_i_valid); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (rsa_i_valid !== 1'b0) $display("FAIL mid_async: i_valid %b expected 0", rsa_i_valid); else pass_cnt++;
    tick();
    tick();
    rst_n = 1'b1;
    clear_model();
    tick();
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL mid_in_ready: got %b expected 1", in_ready); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL mid_out_valid: got %b expected 0", out_valid); else pass_cnt++;
    total_cnt++; if (sent_cnt !== 16'd0 || recv_cnt !== 16'd0 || outstanding !== 3'd0)
      $display("FAIL mid_counters: sent %0d recv %0d outstanding %0d expected 0 0 0", sent_cnt, recv_cnt, outstanding); else pass_cnt++;
    total_cnt++; if (rsa_i_valid !== 1'b0) $display("FAIL mid_idle: i_valid %b expected 0", rsa_i_valid); else pass_cnt++;
  endtask

  initial begin
    do_reset();
    test_reset();
    test_back_to_back();
    test_ack_stall();
    test_credit_stall();
    test_max_outstanding();
    test_err_clr();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
